// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared definitions for the RV32M multiply/divide unit:
//               funct3 operation codes, FSM state encoding, default width
//               and small operand-signedness helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  localparam int XLEN_DEF = 32;

  // funct3 operation codes of the M extension
  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // rs1 is interpreted as two's complement for these operations
  function automatic logic op_signed_a(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
           (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // rs2 is interpreted as two's complement for these operations
  function automatic logic op_signed_b(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) ||
           (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // Remainder takes the dividend's sign rather than the quotient's
  function automatic logic op_is_rem(input logic [2:0] f3);
    return (f3 == F3_REM) || (f3 == F3_REMU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_divider.sv
`default_nettype none
// ============================================================================
// Module      : serial_divider
// Description : Unsigned restoring divider datapath. Loads dividend/divisor,
//               then produces one quotient bit per i_step cycle. The next
//               quotient/remainder values are exposed combinationally so the
//               owner can capture the final result on the last step edge.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_step,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_quot_nxt,
  output logic [XLEN-1:0] o_rem_nxt
);

  logic [XLEN-1:0] r_quot;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_divisor;

  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;
  logic            w_fits;

  // Shift the next dividend bit into the partial remainder and trial-subtract
  always_comb begin
    w_shift    = {r_rem, r_quot[XLEN-1]};
    w_diff     = w_shift - {1'b0, r_divisor};
    w_fits     = ~w_diff[XLEN];
    o_rem_nxt  = w_fits ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
    o_quot_nxt = {r_quot[XLEN-2:0], w_fits};
  end

  // Load operands on accept; advance one quotient bit per step
  always_ff @(posedge clk) begin
    if (rst) begin
      r_quot    <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
    end else if (i_load) begin
      r_quot    <= i_dividend;
      r_rem     <= '0;
      r_divisor <= i_divisor;
    end else if (i_step) begin
      r_quot    <= o_quot_nxt;
      r_rem     <= o_rem_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M multiply/divide unit. Operands are latched as
//               magnitudes plus a result-sign flag; a shift-add multiplier or
//               the serial_divider runs XLEN steps, then the sign is restored.
//               Divide-by-zero and signed overflow finish without iterating.
//               Optional build macro MULDIV_FAST_MUL_EN: multiplies complete
//               in a single cycle using a '*' operator (division unchanged).
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic [XLEN-1:0] MulDivResult,
  output logic            done,
  output logic            busy,
  output logic            stall
);

  localparam logic [XLEN-1:0] c_INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e            r_state;
  logic [CNT_W-1:0]  r_count;
  logic [2:0]        r_f3;
  logic              r_neg;
  logic [XLEN-1:0]   r_mcand;
  logic [2*XLEN-1:0] r_prod;
  logic              r_done;
  logic [XLEN-1:0]   r_result;

  logic              w_sa;
  logic              w_sb;
  logic [XLEN-1:0]   w_abs_a;
  logic [XLEN-1:0]   w_abs_b;
  logic              w_neg_in;
  logic              w_div_zero;
  logic              w_div_ovf;
  logic              w_special;
  logic [XLEN-1:0]   w_special_res;
  logic [XLEN:0]     w_add;
  logic [2*XLEN-1:0] w_prod_nxt;
  logic [XLEN-1:0]   w_quot_nxt;
  logic [XLEN-1:0]   w_rem_nxt;
  logic [XLEN-1:0]   w_iter_res;
  logic              w_div_load;
  logic              w_div_step;

  // Apply the sign correction and pick the architectural result word
  function automatic logic [XLEN-1:0] f_result(
    input logic [2:0]        f3,
    input logic              neg,
    input logic [2*XLEN-1:0] prod,
    input logic [XLEN-1:0]   quot,
    input logic [XLEN-1:0]   rem
  );
    logic [2*XLEN-1:0] p_fix;
    logic [XLEN-1:0]   d_sel;
    p_fix = neg ? -prod : prod;
    d_sel = f3[1] ? rem : quot;
    if (f3[2])
      return neg ? -d_sel : d_sel;
    else if (f3 == F3_MUL)
      return p_fix[XLEN-1:0];
    else
      return p_fix[2*XLEN-1:XLEN];
  endfunction

  // Operand magnitudes, result sign and no-iteration special cases
  always_comb begin
    w_sa          = SrcA[XLEN-1] & op_signed_a(funct3);
    w_sb          = SrcB[XLEN-1] & op_signed_b(funct3);
    w_abs_a       = w_sa ? -SrcA : SrcA;
    w_abs_b       = w_sb ? -SrcB : SrcB;
    w_neg_in      = op_is_rem(funct3) ? w_sa : (w_sa ^ w_sb);
    w_div_zero    = funct3[2] & (SrcB == '0);
    w_div_ovf     = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &
                    (SrcA == c_INT_MIN) & (SrcB == '1);
    w_special     = w_div_zero | w_div_ovf;
    // funct3[1] distinguishes REM/REMU from DIV/DIVU
    w_special_res = w_div_zero ? (funct3[1] ? SrcA : '1)
                               : (funct3[1] ? '0   : c_INT_MIN);
  end

  // One shift-add multiply step: conditionally add, then shift right
  always_comb begin
    w_add      = {1'b0, r_prod[2*XLEN-1:XLEN]} +
                 (r_prod[0] ? {1'b0, r_mcand} : {(XLEN+1){1'b0}});
    w_prod_nxt = {w_add, r_prod[XLEN-1:1]};
    w_iter_res = f_result(r_f3, r_neg, w_prod_nxt, w_quot_nxt, w_rem_nxt);
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fast_prod;
  logic [XLEN-1:0]   w_fast_res;

  // Single-cycle magnitude product, sign-fixed by the shared result path
  always_comb begin
    w_fast_prod = {{XLEN{1'b0}}, w_abs_a} * {{XLEN{1'b0}}, w_abs_b};
    w_fast_res  = f_result(funct3, w_neg_in, w_fast_prod, '0, '0);
  end
`endif

  assign w_div_load = (r_state == ST_IDLE) & start;
  assign w_div_step = (r_state == ST_CALC) & r_f3[2];

  serial_divider #(
    .XLEN (XLEN)
  ) u_serial_divider (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_div_load),
    .i_step     (w_div_step),
    .i_dividend (w_abs_a),
    .i_divisor  (w_abs_b),
    .o_quot_nxt (w_quot_nxt),
    .o_rem_nxt  (w_rem_nxt)
  );

  // Control FSM: accept, iterate XLEN steps, present result for one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_f3     <= '0;
      r_neg    <= 1'b0;
      r_mcand  <= '0;
      r_prod   <= '0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_f3    <= funct3;
            r_neg   <= w_neg_in;
            r_mcand <= w_abs_b;
            r_prod  <= {{XLEN{1'b0}}, w_abs_a};
            r_count <= '0;
            if (w_special) begin
              r_result <= w_special_res;
              r_done   <= 1'b1;
              r_state  <= ST_DONE;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (!funct3[2]) begin
              r_result <= w_fast_res;
              r_done   <= 1'b1;
              r_state  <= ST_DONE;
            end
`endif
            else begin
              r_state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          r_count <= r_count + 1'b1;
          if (!r_f3[2])
            r_prod <= w_prod_nxt;
          if (r_count == CNT_W'(XLEN - 1)) begin
            r_result <= w_iter_res;
            r_done   <= 1'b1;
            r_state  <= ST_DONE;
          end
        end
        // start still high here belongs to the finishing instruction
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign MulDivResult = r_result;
  assign done         = r_done;
  assign busy         = (r_state != ST_IDLE);
  assign stall        = start & ~r_done;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Scoreboard bench for muldiv_unit. A driver issues directed and
//               random operations and queues reference results; a monitor
//               pops and compares on every done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [31:0] MulDivResult;
  logic        done;
  logic        busy;
  logic        stall;

  muldiv_unit dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .funct3       (funct3),
    .SrcA         (SrcA),
    .SrcB         (SrcB),
    .MulDivResult (MulDivResult),
    .done         (done),
    .busy         (busy),
    .stall        (stall)
  );

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          issue;
    logic [2:0]  f3;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   abort_phase = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference results straight from the RV32M arithmetic definitions
  function automatic logic [31:0] ref_model(input logic [2:0] f,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa, sb, ub, p;
    longint unsigned pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'h0, b});
    case (f)
      F3_MUL:    begin p = sa * sb; return p[31:0]; end
      F3_MULH:   begin p = sa * sb; return p[63:32]; end
      F3_MULHSU: begin p = sa * ub; return p[63:32]; end
      F3_MULHU:  begin pu = {32'h0, a} * {32'h0, b}; return pu[63:32]; end
      F3_DIV:    begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = sa / sb;
        return p[31:0];
      end
      F3_DIVU:   begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      F3_REM:    begin
        if (b == 0) return a;
        p = sa % sb;
        return p[31:0];
      end
      default:   begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Cycles from the accepting edge's cycle to the done cycle
  function automatic int exp_lat(input logic [2:0] f,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    if (f < 3'd4) begin
`ifdef MULDIV_FAST_MUL_EN
      return 1;
`else
      return 33;
`endif
    end
    if (b == 0) return 1;
    if (((f == F3_DIV) || (f == F3_REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF))
      return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic finish_sim();
    repeat (2) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected actual=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  // Issue one operation (called at a negedge) and wait for its done pulse.
  // chained: the previous op's DONE cycle is now, so acceptance is one cycle later.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input bit chained, input bit scramble);
    exp_t e;
    int   n;
    funct3  = f;
    SrcA    = a;
    SrcB    = b;
    start   = 1'b1;
    e.res   = ref_model(f, a, b);
    e.lat   = exp_lat(f, a, b);
    e.issue = chained ? cyc + 1 : cyc;
    e.f3    = f;
    q.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (scramble && n == 2) begin
        SrcA   = $urandom;
        SrcB   = $urandom;
        funct3 = 3'($urandom);
      end
    end while (!done && n < 100);
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL done_timeout actual=no_done required=done f3=%0d", f);
      finish_sim();
    end
  endtask

  // Monitor: checks stall/busy every cycle and pops the scoreboard on done
  initial begin
    exp_t e;
    bit   eb;
    forever begin
      @(negedge clk);
      if (!rst) begin
        checks++;
        if (stall !== (start & ~done)) begin
          errors++;
          $display("FAIL stall actual=%b required=%b", stall, start & ~done);
        end
        if (!abort_phase) begin
          eb = (q.size() > 0) && (cyc - q[0].issue >= 1);
          checks++;
          if (busy !== eb) begin
            errors++;
            $display("FAIL busy actual=%b required=%b cyc=%0d", busy, eb, cyc);
          end
        end
        if (done) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL spurious_done actual=done required=no_done cyc=%0d", cyc);
          end else begin
            e = q.pop_front();
            if (MulDivResult !== e.res) begin
              errors++;
              $display("FAIL result f3=%0d actual=%h required=%h", e.f3, MulDivResult, e.res);
            end
            checks++;
            if ((cyc - e.issue) != e.lat) begin
              errors++;
              $display("FAIL latency f3=%0d actual=%0d required=%0d", e.f3, cyc - e.issue, e.lat);
            end
          end
        end
      end
    end
  end

  logic [2:0]  d_f3 [14] = '{F3_MUL, F3_MULHU, F3_MULH, F3_MULHSU, F3_DIV, F3_REM, F3_DIVU,
                             F3_REMU, F3_DIV, F3_REM, F3_DIV, F3_REM, F3_DIVU, F3_REMU};
  logic [31:0] d_a  [14] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -32'sd7, -32'sd7,
                             32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000,
                             32'd9, 32'd9};
  logic [31:0] d_b  [14] = '{-32'sd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2,
                             32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'd0, 32'd0};

  // Main stimulus
  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    funct3 = 3'd0;
    SrcA   = 32'h0;
    SrcB   = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset_done", {31'h0, done}, 32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_result", MulDivResult, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Directed operations, each separated by an idle cycle
    for (int i = 0; i < 14; i++) begin
      run_op(d_f3[i], d_a[i], d_b[i], 1'b0, 1'b0);
      start = 1'b0;
      @(negedge clk);
    end

    // Back-to-back: start held through DONE, next op presented immediately
    run_op(F3_MUL, 32'd7, -32'sd3, 1'b0, 1'b0);
    run_op(F3_DIV, -32'sd7, 32'd2, 1'b1, 1'b0);
    run_op(F3_DIV, 32'd5, 32'd0, 1'b1, 1'b0);
    run_op(F3_REMU, 32'd100, 32'd7, 1'b1, 1'b0);
    start = 1'b0;
    @(negedge clk);

    // Reset mid-DIVU aborts without a done pulse
    abort_phase = 1'b1;
    funct3 = F3_DIVU;
    SrcA   = 32'd1000;
    SrcB   = 32'd3;
    start  = 1'b1;
    repeat (10) @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_done", {31'h0, done}, 32'h0);
    repeat (3) @(negedge clk);
    chk("abort_idle_busy", {31'h0, busy}, 32'h0);
    abort_phase = 1'b0;

    // Fresh start after abort
    run_op(F3_DIVU, 32'd1000, 32'd3, 1'b0, 1'b0);
    start = 1'b0;
    @(negedge clk);

    // Randomized operations with random gaps, chaining and operand churn
    for (int i = 0; i < 60; i++) begin
      bit chained;
      chained = (i > 0) && ($urandom_range(0, 1) == 1);
      if (!chained) begin
        start = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      run_op(3'($urandom_range(0, 7)), pick(), pick(), chained, 1'($urandom_range(0, 1)));
    end
    start = 1'b0;
    finish_sim();
  end

endmodule
`default_nettype wire
